// File: rtl/qspi_arb_pkg.sv
// Shared types for the QSPI flash arbiter: FSM states, owner codes and the pin bundle.
package qspi_arb_pkg;

  localparam int QSPI_DQ_W = 4;

  typedef enum logic [1:0] {IDLE, GRANT_M0, GRANT_M1, DEAD} arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  typedef struct packed {
    logic                 sck;
    logic                 cs_n;
    logic [QSPI_DQ_W-1:0] oval;
    logic [QSPI_DQ_W-1:0] oe;
  } qspi_pins_t;

  // Pad state when nobody owns the flash: deselected, not driving.
  function automatic qspi_pins_t pins_idle(input logic sck_idle);
    pins_idle = '{sck: sck_idle, cs_n: 1'b1, oval: '0, oe: '0};
  endfunction

endpackage

// File: rtl/qspi_arb_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module qspi_arb_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n)               cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/qspi_flash_arbiter.sv
// Two-master arbiter for one QSPI flash pin set with dead time between owners.
// Define QSPI_ARB_TIMEOUT_EN to build the MAX_HOLD grant timeout and preempt pulse.
module qspi_flash_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int   DEAD_CYCLES = 2,
  parameter int   MAX_HOLD    = 1024,
  parameter bit   PRIORITY_M0 = 1'b1,
  parameter logic SCK_IDLE    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 m0_req,
  output logic                 m0_gnt,
  input  logic                 m0_sck,
  input  logic                 m0_cs_n,
  input  logic [QSPI_DQ_W-1:0] m0_dq_oval,
  input  logic [QSPI_DQ_W-1:0] m0_dq_oe,
  output logic [QSPI_DQ_W-1:0] m0_dq_ival,
  input  logic                 m1_req,
  output logic                 m1_gnt,
  input  logic                 m1_sck,
  input  logic                 m1_cs_n,
  input  logic [QSPI_DQ_W-1:0] m1_dq_oval,
  input  logic [QSPI_DQ_W-1:0] m1_dq_oe,
  output logic [QSPI_DQ_W-1:0] m1_dq_ival,
  output logic                 pad_sck,
  output logic                 pad_cs_n,
  output logic [QSPI_DQ_W-1:0] pad_dq_oval,
  output logic [QSPI_DQ_W-1:0] pad_dq_oe,
  input  logic [QSPI_DQ_W-1:0] pad_dq_ival,
  output logic [1:0]           owner,
  output logic                 preempt
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  if (DEAD_CYCLES < 1 || MAX_HOLD < 1) begin : g_param_err
    $error("qspi_flash_arbiter: DEAD_CYCLES and MAX_HOLD must be >= 1");
  end

  arb_state_e state, state_nxt;
  qspi_pins_t m0_pins, m1_pins, pads_q, pads_nxt;
  logic       last_m1, m0_rq, m1_rq, any_rq, pick_m1;
  logic       in_grant, dead_done, revoke;

  assign m0_pins  = '{sck: m0_sck, cs_n: m0_cs_n, oval: m0_dq_oval, oe: m0_dq_oe};
  assign m1_pins  = '{sck: m1_sck, cs_n: m1_cs_n, oval: m1_dq_oval, oe: m1_dq_oe};
  assign in_grant = (state == GRANT_M0) || (state == GRANT_M1);
  assign any_rq   = m0_rq || m1_rq;
  // Tie rule: fixed m0 priority, or the previous owner yields.
  assign pick_m1  = m1_rq && (!m0_rq || (!PRIORITY_M0 && !last_m1));

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic blk_m0, blk_m1, other_rq, own_cs_n, hold_done;

  assign m0_rq    = m0_req && !blk_m0;
  assign m1_rq    = m1_req && !blk_m1;
  assign other_rq = (state == GRANT_M0) ? m1_rq : m0_rq;
  assign own_cs_n = (state == GRANT_M1) ? m1_cs_n : m0_cs_n;

  qspi_arb_timer #(.W(HOLD_W)) u_hold_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (!in_grant || !other_rq),
    .load_val (HOLD_W'(MAX_HOLD)),
    .en       (1'b1),
    .done     (hold_done)
  );

  // Timed-out grant is only pulled between transactions.
  assign revoke = in_grant && other_rq && hold_done && own_cs_n;

  // A revoked master stays masked until it drops req and asks again.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blk_m0 <= 1'b0;
      blk_m1 <= 1'b0;
    end else begin
      if (revoke && state == GRANT_M0) blk_m0 <= 1'b1;
      else if (!m0_req)                blk_m0 <= 1'b0;
      if (revoke && state == GRANT_M1) blk_m1 <= 1'b1;
      else if (!m1_req)                blk_m1 <= 1'b0;
    end
  end
`else
  assign m0_rq  = m0_req;
  assign m1_rq  = m1_req;
  assign revoke = 1'b0;
`endif

  qspi_arb_timer #(.W(DEAD_W)) u_dead_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state_nxt == DEAD && state != DEAD),
    .load_val (DEAD_W'(DEAD_CYCLES - 1)),
    .en       (state == DEAD),
    .done     (dead_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_rq) state_nxt = pick_m1 ? GRANT_M1 : GRANT_M0;
      GRANT_M0: if ((!m0_req && m0_cs_n) || revoke) state_nxt = DEAD;
      GRANT_M1: if ((!m1_req && m1_cs_n) || revoke) state_nxt = DEAD;
      DEAD:     if (dead_done) state_nxt = !any_rq ? IDLE : (pick_m1 ? GRANT_M1 : GRANT_M0);
      default:  state_nxt = IDLE;
    endcase
  end

  // Pads follow the next owner so they go idle on the very edge the grant ends.
  always_comb begin
    pads_nxt = pins_idle(SCK_IDLE);
    if (state_nxt == GRANT_M0)      pads_nxt = m0_pins;
    else if (state_nxt == GRANT_M1) pads_nxt = m1_pins;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      owner   <= OWN_NONE;
      preempt <= 1'b0;
      last_m1 <= 1'b0;
      pads_q  <= pins_idle(SCK_IDLE);
    end else begin
      state   <= state_nxt;
      m0_gnt  <= (state_nxt == GRANT_M0);
      m1_gnt  <= (state_nxt == GRANT_M1);
      owner   <= (state_nxt == GRANT_M0) ? OWN_M0 :
                 (state_nxt == GRANT_M1) ? OWN_M1 : OWN_NONE;
      preempt <= revoke;
      pads_q  <= pads_nxt;
      if (state_nxt == GRANT_M0)      last_m1 <= 1'b0;
      else if (state_nxt == GRANT_M1) last_m1 <= 1'b1;
    end
  end

  assign pad_sck     = pads_q.sck;
  assign pad_cs_n    = pads_q.cs_n;
  assign pad_dq_oval = pads_q.oval;
  assign pad_dq_oe   = pads_q.oe;

  assign m0_dq_ival = pad_dq_ival & {QSPI_DQ_W{owner == OWN_M0}};
  assign m1_dq_ival = pad_dq_ival & {QSPI_DQ_W{owner == OWN_M1}};

endmodule

// File: doc/qspi_flash_arbiter.md
Name: qspi_flash_arbiter

Overview:
Shares the single external QSPI flash pin set (sck, cs_0, dq[3:0]) between two masters: m0 is the E300 QSPI controller, m1 is an FPGA-side flash reader or loader. The block uses a req/gnt handshake and changes owner only between transactions, with a dead-time gap between owners. It sits between the E300 platform's qspi pin bundle and the pad-level tristate logic in the top-level wrapper. Pad outputs are registered; the read-data return path is combinational.

Parameters:
DEAD_CYCLES, 2, idle cycles forced on the pads between two ownerships (min 1)
MAX_HOLD, 1024, cycles an owner may keep grant while the other master waits (timeout feature only)
PRIORITY_M0, 1, 1 = m0 wins simultaneous requests; 0 = round-robin (last owner loses ties)
SCK_IDLE, 0, pad_sck value when no master owns the bus

Ports:
clock  in  1  single system clock
reset_n  in  1  synchronous, active-low reset
m0_req  in  1  m0 requests the bus
m0_gnt  out  1  m0 owns the bus
m0_sck  in  1  m0 serial clock
m0_cs_n  in  1  m0 chip select (low = transaction active)
m0_dq_oval  in  4  m0 data out
m0_dq_oe  in  4  m0 output enables
m0_dq_ival  out  4  pad data to m0 (zero when not owner)
m1_req, m1_gnt, m1_sck, m1_cs_n, m1_dq_oval, m1_dq_oe, m1_dq_ival  as m0
pad_sck  out  1  to flash
pad_cs_n  out  1  to flash
pad_dq_oval  out  4  to tristate buffers
pad_dq_oe  out  4  to tristate buffers
pad_dq_ival  in  4  from pads
owner  out  2  00 none/dead, 01 m0, 10 m1
preempt  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Clocking: one clock. Reset is synchronous and active-low. All flops update on the rising edge of clock.
- Reset values: state IDLE, gnt 0/0, owner 00, preempt 0, pad_cs_n 1, pad_sck SCK_IDLE, pad_dq_oval 0, pad_dq_oe 0, all counters 0.
- States:
  - IDLE: on a pending req, go to GRANT_M0 or GRANT_M1 at the same edge.
    - Both pending: pick by PRIORITY_M0. In round-robin mode the last owner loses; after reset m0 counts as last owner, so m1 wins.
  - GRANT_Mx: mx_gnt = 1, owner = x.
    - Exit to DEAD when mx_req = 0 and mx_cs_n = 1, sampled at the same edge.
    - If req falls while cs_n = 0, hold the grant until cs_n = 1, so a transaction is never cut.
  - DEAD: hold pads idle (cs_n 1, sck SCK_IDLE, oe 0) for exactly DEAD_CYCLES cycles.
    - Then go to GRANT of a pending requester (same tie rule), else to IDLE.
- Handshake:
  - gnt is a registered state decode. A req sampled at edge N gives gnt high from cycle N+1.
  - A master must keep cs_n high until it sees gnt. Inputs from a non-owner are ignored.
  - The owner may keep req high indefinitely.
- Pad outputs: registered mux of the owner's sck/cs_n/oval/oe, one cycle of latency. In IDLE and DEAD the pads show the reset values.
- Read path: mx_dq_ival = pad_dq_ival & {4{owner==x}}, combinational with no register. The master samples with its own timing, which is offset by the one-cycle output latency.
- Reset mid-transfer: the next edge returns everything to reset values. pad_cs_n goes high immediately, with no dead time.

Optional Feature:
Macro: QSPI_ARB_TIMEOUT_EN
- With the macro:
  - A hold counter (clog2(MAX_HOLD+1) bits) increments each cycle in GRANT_Mx while the other req is high. It clears on any state change or when the other req drops.
  - When the count reaches MAX_HOLD and mx_cs_n = 1, the grant is revoked: mx_gnt drops, preempt pulses for 1 cycle, and the state goes to DEAD.
  - If cs_n = 0 at that point, revoke at the first cycle cs_n = 1.
  - The revoked master must re-request.
- Without the macro: no counter is built, preempt is tied 0, and the owner keeps the bus until it releases.

Decomposition:
- Package qspi_arb_pkg holds:
  - state enum (IDLE, GRANT_M0, GRANT_M1, DEAD)
  - owner encodings OWN_NONE/OWN_M0/OWN_M1
  - QSPI_DQ_W = 4
- One sub-module, qspi_arb_timer: a loadable down-counter with done flag. It is instantiated for dead time and, under the macro, for the hold timeout.

Test Plan:
- Reset: hold reset_n low 3 cycles with both req high -> pad_cs_n=1, pad_dq_oe=0, pad_sck=0, gnt=00, owner=00.
- Single owner: m0_req=1 at edge 0 -> m0_gnt=1 from cycle 1. Drive m0_cs_n=0, oval=4'hA, oe=4'h1 -> pads show these one cycle later. pad_dq_ival=4'h5 -> m0_dq_ival=5, m1_dq_ival=0.
- Tie in round-robin (PRIORITY_M0=0): after an m0 ownership, both req rise in IDLE -> m1_gnt=1, m0_gnt=0.
- Protected release: m0 drops req with m0_cs_n=0 for 7 more cycles, m1_req=1 -> m0_gnt stays 1 until cs_n=1. Then exactly 2 DEAD cycles (pad_cs_n=1, oe=0), then m1_gnt=1.
- Timeout (macro on, MAX_HOLD=16): m0 holds req, cs_n=1, m1 requests -> after 16 cycles m0_gnt drops, preempt pulses once, m1_gnt after 2 dead cycles. Macro off: m0 keeps the grant for 1000+ cycles.
- Reset mid-transfer: reset_n=0 while m1 owns with cs_n=0 -> next edge pad_cs_n=1, m1_gnt=0, owner=00.
